if_id_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Delivers {instr, pc, valid} to decode, where the immediate generator and control unit consume instr_o.
- Honours load-use stall and branch redirect/flush from ID.

---
 rtl/if_id_fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_if_id_fetch_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the RV32I core.
// Defining FETCH_PERF_CNT_EN adds the perf_fetch_o / perf_stall_o event counters.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o,
`endif
  output logic        busy_o
);

  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [31:0] PcStep = 32'(PC_STEP);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        load_en;
  logic        enter;
  logic [31:0] load_instr;
  logic [31:0] load_pc;
  state_e      resume_state;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    kill_d       = kill_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    load_en      = 1'b0;
    load_instr   = imem_data_i;
    load_pc      = fetch_pc_q;
    enter        = 1'b0;
    // Once a transaction retires, a dropped start_i parks the stage in idle.
    resume_state = start_i ? StFetch : StIdle;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack_i) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = resume_state;
          end else if (stall_i) begin
            hold_instr_d = imem_data_i;
            hold_pc_d    = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + PcStep;
            state_d      = StHold;
          end else begin
            load_en    = 1'b1;
            fetch_pc_d = fetch_pc_q + PcStep;
            state_d    = resume_state;
          end
        end
      end
      StHold: begin
        if (!stall_i) begin
          load_en    = 1'b1;
          load_instr = hold_instr_q;
          load_pc    = hold_pc_q;
          state_d    = resume_state;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_en) begin
      instr_d = load_instr;
      pc_d    = load_pc;
      valid_d = 1'b1;
      enter   = 1'b1;
    end

    if (branch_taken_i) begin
      fetch_pc_d = branch_target_i & ~32'h3;
      valid_d    = 1'b0;
      instr_d    = Nop;
      enter      = 1'b0;
      unique case (state_q)
        StFetch: begin
          // A request already on the bus must complete; its response gets dropped.
          if (imem_ack_i) begin
            kill_d  = 1'b0;
            state_d = resume_state;
          end else begin
            kill_d = 1'b1;
          end
        end
        StHold:  state_d = resume_state;
        default: ;
      endcase
    end else if (flush_i) begin
      valid_d = 1'b0;
      instr_d = Nop;
      enter   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      kill_q       <= 1'b0;
      hold_instr_q <= Nop;
      hold_pc_q    <= 32'h0;
      instr_q      <= Nop;
      pc_q         <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      kill_q       <= kill_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      if (enter)              perf_fetch_q <= perf_fetch_q + 32'h1;
      if (stall_i && valid_q) perf_stall_q <= perf_stall_q + 32'h1;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_stall_o = perf_stall_q;
`endif

  assign imem_req_o  = (state_q == StFetch);
  assign busy_o      = (state_q == StFetch);
  assign imem_addr_o = fetch_pc_q;
  assign instr_o     = valid_q ? instr_q : Nop;
  assign pc_o        = pc_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: a transaction-level fetch model feeds an
// expected IF/ID stream that a negedge monitor consumes.
module tb_if_id_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, start, stall, flush, br, ack;
  logic [31:0] tgt, data;
  logic        imem_req_o, valid_o, busy_o;
  logic [31:0] imem_addr_o, instr_o, pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_o, perf_stall_o;
`endif

  if_id_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (ack),
    .imem_data_i     (data),
    .stall_i         (stall),
    .flush_i         (flush),
    .branch_taken_i  (br),
    .branch_target_i (tgt),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .valid_o         (valid_o),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_o    (perf_fetch_o),
    .perf_stall_o    (perf_stall_o),
`endif
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: next fetch address, outstanding request, poisoned response,
  // parked responses, and the stream of instructions expected to reach decode.
  logic [31:0] m_pc;
  bit          m_busy, m_poison, m_valid, m_just_reset;
  ent_t        m_parked[$];
  ent_t        exp_q[$];
  int unsigned m_pf, m_ps;
  bit          chk_en = 1'b0;
  int          n_checks = 0, n_fail = 0;
  bit          prev_v = 1'b0;
  logic [31:0] prev_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic model_step();
    bit   holding, take;
    ent_t e;
    m_just_reset = rst;
    if (rst) begin
      m_pc = 32'h0; m_busy = 0; m_poison = 0; m_valid = 0;
      m_parked.delete(); exp_q.delete(); m_pf = 0; m_ps = 0;
      return;
    end
    if (stall && m_valid) m_ps++;
    holding = (m_parked.size() != 0);
    take    = 0;
    e       = '0;
    if (br) begin
      if (m_busy) begin
        if (ack) begin m_poison = 0; m_busy = start; end
        else m_poison = 1;
      end else if (holding) begin
        m_parked.delete(); m_busy = start;
      end else if (start) begin
        m_busy = 1;
      end
      m_pc    = tgt & ~32'h3;
      m_valid = 0;
    end else begin
      if (m_busy && ack) begin
        if (m_poison) begin
          m_poison = 0; m_busy = start;
        end else if (stall) begin
          m_parked.push_back('{pc: m_pc, instr: data});
          m_pc = m_pc + 4; m_busy = 0;
        end else begin
          e = '{pc: m_pc, instr: data}; take = 1;
          m_pc = m_pc + 4; m_busy = start;
        end
      end else if (holding && !stall) begin
        e = m_parked.pop_front(); take = 1; m_busy = start;
      end else if (!m_busy && !holding && start) begin
        m_busy = 1;
      end
      if (flush) begin take = 0; m_valid = 0; end
      if (take) begin exp_q.push_back(e); m_valid = 1; m_pf++; end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit stl, input bit fl, input bit b,
                     input logic [31:0] t, input bit a);
    rst = r; start = s; stall = stl; flush = fl; br = b; tgt = t; ack = a;
    data = mem_word(m_pc);
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", 32'(imem_req_o), 32'(m_busy));
      check("busy", 32'(busy_o), 32'(m_busy));
      check("imem_addr", imem_addr_o, m_pc);
      check("valid", 32'(valid_o), 32'(m_valid));
      if (!valid_o) check("nop_when_invalid", instr_o, Nop);
      if (m_just_reset) check("reset_pc_o", pc_o, 32'h0);
      if (valid_o === 1'b1 && (!prev_v || pc_o !== prev_pc)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ifid_load", pc_o, 32'hxxxx_xxxx);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          check("ifid_pc", pc_o, e.pc);
          check("ifid_instr", instr_o, e.instr);
        end
      end
      check("missed_ifid_loads", 32'(exp_q.size()), 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetch", perf_fetch_o, m_pf);
      check("perf_stall", perf_stall_o, m_ps);
`endif
      prev_v  = (valid_o === 1'b1);
      prev_pc = pc_o;
    end
  end

  initial begin
    m_pc = 32'h0;
    rst = 1; start = 0; stall = 0; flush = 0; br = 0; tgt = 0; ack = 0; data = 0;
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
    // Back-to-back single-cycle acks.
    repeat (8) cyc(0, 1, 0, 0, 0, 0, 1);
    // Three-cycle ack latency.
    repeat (3) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 1);
    end
    // Stall coinciding with an ack, held four cycles.
    cyc(0, 1, 1, 0, 0, 0, 1);
    repeat (3) cyc(0, 1, 1, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 0, 0, 0, 0, 1);
    // Redirect while a request is in flight; its ack arrives two cycles later.
    cyc(0, 1, 0, 0, 1, 32'h0000_0103, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 1);
    // Stall and redirect together, then flush alone.
    cyc(0, 1, 1, 0, 1, 32'h0000_0200, 0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 0, 0, 1);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1, 32'h0000_0300, 1);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 1);
    // PC wrap past 0xFFFF_FFFC.
    cyc(0, 1, 0, 0, 1, 32'hFFFF_FFF8, 1);
    repeat (5) cyc(0, 1, 0, 0, 0, 0, 1);
    // start_i drop: the outstanding request completes, then idle.
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
    repeat (4) cyc(0, 1, 0, 0, 0, 0, 1);
    // Reset mid-request, followed by a late ack.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 599) == 0, $urandom_range(0, 15) != 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 12) == 0,
          $urandom_range(0, 10) == 0,
          ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : 32'($urandom),
          $urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
